// File: rtl/bcd_gray_pkg.sv
// Shared Gray-code definitions: code width, code type and the binary<->Gray
// conversion functions used by any Gray-pointer logic in the codebase.
package bcd_gray_pkg;

  localparam int GRAY_W = 4;

  typedef logic [GRAY_W-1:0] gray_t;

  function automatic gray_t bin2gray(input gray_t bin);
    return bin ^ (bin >> 1);
  endfunction

  // Each binary bit is the XOR of all Gray bits at or above it, so the
  // decode ripples down from the MSB.
  function automatic gray_t gray2bin(input gray_t gray);
    gray_t bin;
    bin[GRAY_W-1] = gray[GRAY_W-1];
    for (int i = GRAY_W - 2; i >= 0; i--) begin
      bin[i] = bin[i+1] ^ gray[i];
    end
    return bin;
  endfunction

endpackage

// File: rtl/bcd_gray_enc4.sv
// Purely combinational 4-bit binary->Gray encoder with a Gray->binary
// decode of its own output, so the round trip is observable.
module gray_enc4
  import bcd_gray_pkg::*;
(
  input  logic [GRAY_W-1:0] b,
  output logic [GRAY_W-1:0] g,
  output logic [GRAY_W-1:0] b_back
);

  assign g      = bin2gray(b);
  assign b_back = gray2bin(g);

endmodule

// File: rtl/bcd_gray.sv
// Binary-to-Gray converter with a registered Gray output, a BCD-digit flag
// and a flag showing the registered code moved by at most one bit.
module bcd_gray
  import bcd_gray_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [GRAY_W-1:0] b,
  output logic [GRAY_W-1:0] g,
  output logic [GRAY_W-1:0] g_q,
  output logic              bcd_ok_q,
  output logic              step_ok_q,
  output logic [GRAY_W-1:0] b_back
);

  logic [GRAY_W-1:0] diff;
  logic              step_ok_d;
  logic              bcd_ok_d;

  gray_enc4 u_enc (
    .b      (b),
    .g      (g),
    .b_back (b_back)
  );

  // At most one bit set <=> clearing the lowest set bit leaves nothing.
  assign diff      = g ^ g_q;
  assign step_ok_d = ((diff & (diff - 4'd1)) == '0);
  assign bcd_ok_d  = (b <= 4'd9);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      g_q       <= '0;
      bcd_ok_q  <= 1'b1;
      step_ok_q <= 1'b1;
    end else begin
      g_q       <= g;
      bcd_ok_q  <= bcd_ok_d;
      step_ok_q <= step_ok_d;
    end
  end

endmodule

// File: tb/tb_bcd_gray.sv
// Self-checking bench for bcd_gray: directed steps followed by random values,
// all checked against a table-driven reference model.
module tb_bcd_gray;

  logic       clk;
  logic       rst;
  logic [3:0] b;
  logic [3:0] g;
  logic [3:0] g_q;
  logic       bcd_ok_q;
  logic       step_ok_q;
  logic [3:0] b_back;

  int checks;
  int passes;

  logic [3:0] exp_q[$];
  logic [3:0] gray_tab[16];
  logic [3:0] model_gq;

  bcd_gray dut (
    .clk       (clk),
    .rst       (rst),
    .b         (b),
    .g         (g),
    .g_q       (g_q),
    .bcd_ok_q  (bcd_ok_q),
    .step_ok_q (step_ok_q),
    .b_back    (b_back)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  // Combinational checks right after b settles.
  task automatic check_comb(input logic [3:0] v);
    check("g_comb", g, gray_tab[v]);
    check("b_back", b_back, v);
  endtask

  // Driver: apply v on the falling edge, then check registered outputs just
  // after the next rising edge against the model.
  task automatic drive_step(input logic [3:0] v);
    logic [3:0] exp_g;
    logic       exp_step;
    @(negedge clk);
    b = v;
    #1;
    check_comb(v);
    exp_step = ($countones(gray_tab[v] ^ model_gq) <= 1);
    model_gq = gray_tab[v];
    exp_q.push_back(gray_tab[v]);
    @(posedge clk);
    #1;
    exp_g = exp_q.pop_front();
    check("g_q", g_q, exp_g);
    check("bcd_ok_q", {3'b0, bcd_ok_q}, {3'b0, (v <= 4'd9)});
    check("step_ok_q", {3'b0, step_ok_q}, {3'b0, exp_step});
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_g_q"}, g_q, 4'b0000);
    check({tag, "_bcd_ok_q"}, {3'b0, bcd_ok_q}, 4'd1);
    check({tag, "_step_ok_q"}, {3'b0, step_ok_q}, 4'd1);
  endtask

  initial begin
    checks = 0;
    passes = 0;
    gray_tab = '{4'b0000, 4'b0001, 4'b0011, 4'b0010, 4'b0110, 4'b0111, 4'b0101, 4'b0100,
                 4'b1100, 4'b1101, 4'b1111, 4'b1110, 4'b1010, 4'b1011, 4'b1001, 4'b1000};
    model_gq = 4'b0000;
    b   = 4'd0;
    rst = 1'b1;
    #2;
    check_reset_vals("reset");

    // Combinational sweep while held in reset, 100 ns per value.
    for (int i = 0; i < 16; i++) begin
      b = 4'(i);
      #100;
      check_comb(4'(i));
    end
    check_reset_vals("reset_hold");

    @(negedge clk);
    rst = 1'b0;

    // Incrementing sweep with wrap back to 0.
    for (int i = 0; i < 16; i++) drive_step(4'(i));
    drive_step(4'd0);

    // BCD boundary.
    drive_step(4'd9);
    drive_step(4'd10);

    // Non-adjacent jump, then a zero-bit hold.
    drive_step(4'd0);
    drive_step(4'd5);
    drive_step(4'd5);

    // Asynchronous reset between edges.
    drive_step(4'd12);
    #2;
    rst = 1'b1;
    #1;
    check_reset_vals("async_rst");
    check("g_during_rst", g, 4'b1010);
    model_gq = 4'b0000;
    @(negedge clk);
    b = 4'd3;
    rst = 1'b0;
    // Re-drive 3 so the model sees it as the first post-reset sample.
    drive_step(4'd3);
    drive_step(4'd4);

    // Random values.
    for (int i = 0; i < 200; i++) drive_step(4'($urandom_range(0, 15)));

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
